// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO widths, depth and Gray-to-binary helper
package fifo_pkg;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEPTH = 2 ** DEF_ADDR_WIDTH;
    function automatic logic [DEF_ADDR_WIDTH:0] gray2bin(input logic [DEF_ADDR_WIDTH:0] g);
        logic [DEF_ADDR_WIDTH:0] b;
        b[DEF_ADDR_WIDTH] = g[DEF_ADDR_WIDTH];
        for (int i = DEF_ADDR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/wr_flow_ctrl_gray2bin.sv
// gray2bin: combinational Gray-to-binary converter of width W
// Ports: gray_i (Gray code in), bin_o (binary out)
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);
    always_comb begin
        bin_o[W-1] = gray_i[W-1];
        for (int i = W - 2; i >= 0; i--) bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
endmodule

// File: rtl/wr_flow_ctrl.sv
// wr_flow_ctrl: write-side skid buffer and fill-level tracker of the async FIFO
// Ports: wr_clk/wr_rst clock and async reset; s_valid/s_ready/s_data upstream handshake;
//        wr_push/wr_data push to write-pointer control, gated by wr_full;
//        wr_ptr/rd_ptr_sync Gray pointers; wr_level/wr_almost_full registered level; skid_occ occupancy
module wr_flow_ctrl
    import fifo_pkg::*;
#(
    parameter int pADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int pDATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int pAFULL_THRESH = 12
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [pDATA_WIDTH-1:0] s_data,
    output logic                   wr_push,
    output logic [pDATA_WIDTH-1:0] wr_data,
    input  logic                   wr_full,
    input  logic [pADDR_WIDTH:0]   wr_ptr,
    input  logic [pADDR_WIDTH:0]   rd_ptr_sync,
    output logic [pADDR_WIDTH:0]   wr_level,
    output logic                   wr_almost_full,
    output logic [1:0]             skid_occ
);
    localparam int PW = pADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL = PW'(pAFULL_THRESH);

    logic [pDATA_WIDTH-1:0] mem_q [2];
    logic                   head_q, tail_q, ready_q, afull_q;
    logic [1:0]             occ_q, occ_d;
    logic [PW-1:0]          level_q, level_c, wr_bin, rd_bin;
    logic                   accept, drain;

    gray2bin #(.W(PW)) u_wr_g2b (.gray_i(wr_ptr),      .bin_o(wr_bin));
    gray2bin #(.W(PW)) u_rd_g2b (.gray_i(rd_ptr_sync), .bin_o(rd_bin));

    assign accept  = s_valid & ready_q;
    // never push while full: the pointer control would silently drop it
    assign drain   = (occ_q != 2'd0) & ~wr_full;
    assign occ_d   = occ_q + {1'b0, accept} - {1'b0, drain};
    // modular subtraction handles the pointer MSB wrap
    assign level_c = wr_bin - rd_bin;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
            ready_q  <= 1'b0;
            level_q  <= '0;
            afull_q  <= 1'b0;
        end else begin
            if (accept) mem_q[tail_q] <= s_data;
            tail_q  <= tail_q ^ accept;
            head_q  <= head_q ^ drain;
            occ_q   <= occ_d;
            ready_q <= occ_d != 2'd2;
            level_q <= level_c;
            afull_q <= level_c >= AFULL;
        end
    end

    assign s_ready        = ready_q;
    assign wr_push        = drain;
    assign wr_data        = mem_q[head_q];
    assign wr_level       = level_q;
    assign wr_almost_full = afull_q;
    assign skid_occ       = occ_q;
endmodule

// File: tb/tb_wr_flow_ctrl.sv
// tb_wr_flow_ctrl: randomized scoreboard bench for wr_flow_ctrl
module tb_wr_flow_ctrl;
    logic       wr_clk = 0, wr_rst = 0, s_valid = 0, wr_full = 0;
    logic [7:0] s_data = 0;
    logic [4:0] wr_ptr = 0, rd_ptr_sync = 0;
    logic       s_ready, wr_push, wr_almost_full;
    logic [7:0] wr_data;
    logic [4:0] wr_level;
    logic [1:0] skid_occ;

    wr_flow_ctrl dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .wr_push(wr_push), .wr_data(wr_data), .wr_full(wr_full),
        .wr_ptr(wr_ptr), .rd_ptr_sync(rd_ptr_sync), .wr_level(wr_level),
        .wr_almost_full(wr_almost_full), .skid_occ(skid_occ)
    );

    always #5 wr_clk = ~wr_clk;

    int         checks = 0, errors = 0;
    logic [7:0] q[$];
    bit         rdy_m = 0;
    int         lvl_m = 0, wb = 0, rb = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gray(int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    task automatic step(bit v, logic [7:0] d, bit f);
        bit acc;
        @(negedge wr_clk);
        s_valid = v; s_data = d; wr_full = f;
        wr_ptr = gray(wb); rd_ptr_sync = gray(rb);
        #1;
        check("push", wr_push, q.size() != 0 && !f);
        check("occ", skid_occ, q.size());
        check("ready", s_ready, rdy_m);
        if (q.size() != 0) check("data", wr_data, q[0]);
        check("level", wr_level, lvl_m);
        check("afull", wr_almost_full, lvl_m >= 12);
        acc = v && rdy_m;
        if (q.size() != 0 && !f) void'(q.pop_front());
        if (acc) q.push_back(d);
        rdy_m = q.size() != 2;
        lvl_m = (wb - rb) & 31;
    endtask

    task automatic do_reset();
        #2 wr_rst = 1;
        #1;
        check("rst_ready", s_ready, 0);
        check("rst_push", wr_push, 0);
        check("rst_data", wr_data, 0);
        check("rst_level", wr_level, 0);
        check("rst_afull", wr_almost_full, 0);
        check("rst_occ", skid_occ, 0);
        q.delete(); rdy_m = 0; lvl_m = 0; wb = 0; rb = 0;
        s_valid = 0; wr_full = 0; wr_ptr = 0; rd_ptr_sync = 0;
        @(posedge wr_clk);
        #2 wr_rst = 0;
    endtask

    initial begin
        do_reset();
        step(0, 0, 0);
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h60 + i), 1);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        wb = 17; rb = 3;
        step(0, 0, 0);
        step(0, 0, 0);
        check("lvl_wrap", wr_level, 14);
        check("afull_wrap", wr_almost_full, 1);
        wb = 16; rb = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        check("lvl_full", wr_level, 16);
        rb = 5;
        step(0, 0, 0);
        step(0, 0, 0);
        check("lvl_11", wr_level, 11);
        check("afull_11", wr_almost_full, 0);
        for (int i = 0; i < 1000; i++) begin
            if (wb - rb < 16 && $urandom_range(0, 1) == 1) wb++;
            if (rb < wb && $urandom_range(0, 2) == 0) rb++;
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        check("drained", skid_occ, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wr_flow_ctrl.md
Name: wr_flow_ctrl

Overview:
Write-side front end of the asynchronous FIFO, placed directly upstream of the write-pointer control block in the wr_clk domain.
- Accepts data over a valid/ready handshake and buffers it in a 2-entry skid buffer.
- Issues wr_push/wr_data only when the FIFO is not full.
- Computes the registered fill level and an almost-full flag from the Gray write pointer and the synchronized Gray read pointer.

Parameters:
pADDR_WIDTH, 4, FIFO address width; depth = 2^pADDR_WIDTH; pointers are pADDR_WIDTH+1 bits
pDATA_WIDTH, 8, data word width
pAFULL_THRESH, 12, level at or above which wr_almost_full asserts (1..2^pADDR_WIDTH)

Ports:
wr_clk  input  1  write-domain clock
wr_rst  input  1  asynchronous, active-high reset
s_valid  input  1  upstream data valid
s_ready  output  1  block can accept a word this cycle
s_data  input  pDATA_WIDTH  upstream data
wr_push  output  1  push request to write-pointer control
wr_data  output  pDATA_WIDTH  word to FIFO memory; valid when wr_push=1
wr_full  input  1  registered full flag from write-pointer control
wr_ptr  input  pADDR_WIDTH+1  Gray write pointer from write-pointer control
rd_ptr_sync  input  pADDR_WIDTH+1  Gray read pointer, already 2-flop synchronized into wr_clk
wr_level  output  pADDR_WIDTH+1  registered FIFO occupancy, 0..2^pADDR_WIDTH
wr_almost_full  output  1  registered; wr_level >= pAFULL_THRESH
skid_occ  output  2  skid-buffer occupancy, 0..2

Behaviour:
Reset (wr_rst=1, asynchronous)
- Skid buffer empty; s_ready=0, wr_push=0, wr_data=0, wr_level=0, wr_almost_full=0, skid_occ=0.
- s_ready rises on the first wr_clk edge after wr_rst deasserts.
- Reset mid-transfer discards buffered words without issuing a push.

Skid buffer (2-entry FIFO, head/tail index registers)
- accept = s_valid & s_ready. Data is captured at the tail.
- drain = (skid_occ != 0) & ~wr_full.
- wr_push = drain, combinational from registers and wr_full.
- wr_data = head entry, held stable while wr_full=1.
- Simultaneous accept and drain: occupancy unchanged; head and tail both advance; data order preserved.
- s_ready is registered: next value = (occ_next != 2). Upstream sees deassertion one cycle after the second word is captured; no word is ever dropped.
- skid_occ = occupancy register.

Full interaction
- While wr_full=1, wr_push is held low and the buffer fills to 2, then s_ready drops.
- The cycle wr_full deasserts, wr_push asserts if skid_occ>0.
- Because wr_full is registered one cycle late relative to the push, the write-pointer control ignores a push issued while full. This block therefore must never assert wr_push while wr_full=1.

Level computation
- Convert wr_ptr and rd_ptr_sync to binary: b[N]=g[N]; b[i]=b[i+1]^g[i].
- level_c = wr_bin - rd_bin, modulo 2^(pADDR_WIDTH+1). This wraps correctly across pointer MSB toggles.
- wr_level is level_c registered (1-cycle latency from pointer change). wr_almost_full is (level_c >= pAFULL_THRESH) registered in the same cycle.
- The level is conservative: the read side lags by synchronizer delay, so the level can over-report but never under-report.

Decomposition:
- Shared package fifo_pkg: pADDR_WIDTH and pDATA_WIDTH defaults, DEPTH = 2^pADDR_WIDTH, and a gray2bin function.
- One natural sub-module: gray2bin, combinational and parameterized by width, instantiated twice (wr_ptr and rd_ptr_sync).
- The skid buffer stays inline.

Test Plan:
1. Reset pulse mid-stream with skid_occ=2 -> all outputs 0 immediately; s_ready=1 one edge after release; no push of stale data.
2. s_valid=1 continuously, wr_full=0, data 0x00..0x0F -> wr_push every cycle after 1-cycle latency; wr_data sequence 0x00..0x0F in order; skid_occ stays <=1.
3. wr_full=1 held for 5 cycles while s_valid=1 -> wr_push=0 throughout; skid_occ reaches 2; s_ready=0 one cycle later. On wr_full=0, the 2 held words push in order before new data; no loss or duplication.
4. wr_ptr=Gray(17)=0x19, rd_ptr_sync=Gray(3)=0x02 (wrap case) -> wr_level=14 and wr_almost_full=1 one cycle later.
5. wr_ptr=Gray(16)=0x18, rd_ptr_sync=Gray(0)=0x00 -> wr_level=16 (full depth); then rd_ptr_sync=Gray(5)=0x07 -> wr_level=11, wr_almost_full=0.
6. Random s_valid and wr_full toggling over 1000 cycles against a scoreboard -> output order equals input order; wr_push never high while wr_full=1.
